// File: rtl/ddr_transmitter_24bit_pkg.sv
// rtl/ddr_transmitter_24bit_pkg.sv - shared link constants, state encoding and helpers
package ddr_transmitter_24bit_pkg;

    localparam logic [23:0] TRAIN_WORD = 24'hA5_5A0F;
    localparam logic [23:0] IDLE_WORD  = 24'h000000;
    localparam int          DDR_W      = 12;

    typedef enum logic [1:0] {
        ST_TRAIN = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SEND  = 2'd2
    } tx_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ddr_transmitter_24bit_if.sv
// rtl/ddr_transmitter_24bit_if.sv - producer-side valid/ready word handshake
interface ddr_transmitter_24bit_if;
    logic [23:0] DATA_IN;
    logic        DATA_VALID;
    logic        DATA_READY;

    modport master (output DATA_IN, output DATA_VALID, input DATA_READY);
    modport slave  (input DATA_IN, input DATA_VALID, output DATA_READY);
endinterface

// File: rtl/ddr_transmitter_24bit_ddr_out_1bit.sv
// rtl/ddr_transmitter_24bit_ddr_out_1bit.sv - one-bit DDR launch cell, d1 on rise, d2 on fall
module ddr_transmitter_24bit_ddr_out_1bit (
    input  logic clk,
    input  logic rst_n,
    input  logic d1,
    input  logic d2,
    output logic q
);
    // Each edge's flop stores its data XOR the other edge's flop, so the XOR
    // of both is the most recently launched bit with no clock-selected mux.
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        rise_d = d1 ^ fall_q;
        fall_d = d2 ^ rise_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rise_q <= 1'b0;
        else        rise_q <= rise_d;
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) fall_q <= 1'b0;
        else        fall_q <= fall_d;
    end

    assign q = rise_q ^ fall_q;
endmodule

// File: rtl/ddr_transmitter_24bit.sv
// rtl/ddr_transmitter_24bit.sv - 24-bit word to 12-bit DDR transmitter with FIFO and training
module ddr_transmitter_24bit
    import ddr_transmitter_24bit_pkg::*;
#(
    parameter int          FIFO_DEPTH      = 4,
    parameter int          TRAIN_CYCLES    = 64,
    parameter logic [31:0] WORDS_SENT_INIT = 32'd0,
    parameter logic [15:0] UNDERRUNS_INIT  = 16'd0
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    ddr_transmitter_24bit_if.slave  in_if,
    input  logic                    TRAIN_REQ,
    output logic                    TRAINING,
    output logic [DDR_W-1:0]        DDR_OUT,
    output logic                    DDR_CLK_OUT,
    output logic [31:0]             WORDS_SENT,
    output logic [15:0]             UNDERRUNS
);
    localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int               CNT_W     = $clog2(TRAIN_CYCLES + 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] TRAIN_END = CNT_W'(TRAIN_CYCLES);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] train_cnt_q, train_cnt_d;
    logic [23:0]      fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   fill_q, fill_d;
    logic [23:0]      tx_reg_q, tx_reg_d;
    logic             tx_train_q, tx_train_d;
    logic [11:0]      tx_hi_q, tx_hi_d;
    logic             training_q, training_d;
    logic [31:0]      words_q, words_d;
    logic [15:0]      under_q, under_d;
    logic             empty, full, ready, push, pop;

    assign empty = (fill_q == '0);
    assign full  = (fill_q == FULL_CNT);
    assign ready = !full && (state_q != ST_TRAIN);
    assign push  = in_if.DATA_VALID && ready;

    assign in_if.DATA_READY = ready;
    assign TRAINING         = training_q;
    assign WORDS_SENT       = words_q;
    assign UNDERRUNS        = under_q;

    always_comb begin
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        tx_reg_d    = IDLE_WORD;
        tx_train_d  = 1'b0;
        pop         = 1'b0;
        under_d     = under_q;
        if (TRAIN_REQ) begin
            state_d     = ST_TRAIN;
            train_cnt_d = CNT_W'(1);
            tx_reg_d    = TRAIN_WORD;
            tx_train_d  = 1'b1;
        end else begin
            case (state_q)
                ST_TRAIN: begin
                    if (train_cnt_q == TRAIN_END) begin
                        pop     = !empty;
                        state_d = empty ? ST_IDLE : ST_SEND;
                    end else begin
                        train_cnt_d = train_cnt_q + CNT_W'(1);
                        tx_reg_d    = TRAIN_WORD;
                        tx_train_d  = 1'b1;
                    end
                end
                ST_IDLE: begin
                    pop     = !empty;
                    state_d = empty ? ST_IDLE : ST_SEND;
                end
                ST_SEND: begin
                    pop = !empty;
                    if (empty) begin
                        state_d = ST_IDLE;
                        under_d = sat_inc16(under_q);
                    end
                end
                default: state_d = ST_TRAIN;
            endcase
        end

        // A pop always lands the FIFO head in TX_REG; idle/training fill never counts.
        words_d = words_q;
        if (pop) begin
            tx_reg_d = fifo_mem_q[rd_ptr_q];
            words_d  = words_q + 32'd1;
        end

        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fill_d     = fill_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        // Upper half must be held a cycle so the fall launch sees the same word as the rise.
        tx_hi_d    = tx_reg_q[23:12];
        training_d = tx_train_q;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= ST_TRAIN;
            train_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            tx_reg_q    <= IDLE_WORD;
            tx_train_q  <= 1'b0;
            tx_hi_q     <= '0;
            training_q  <= 1'b0;
            words_q     <= WORDS_SENT_INIT;
            under_q     <= UNDERRUNS_INIT;
        end else begin
            state_q     <= state_d;
            train_cnt_q <= train_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            tx_reg_q    <= tx_reg_d;
            tx_train_q  <= tx_train_d;
            tx_hi_q     <= tx_hi_d;
            training_q  <= training_d;
            words_q     <= words_d;
            under_q     <= under_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem_q[wr_ptr_q] <= in_if.DATA_IN;
    end

    for (genvar i = 0; i < DDR_W; i++) begin : g_ddr_data
        ddr_transmitter_24bit_ddr_out_1bit u_ddr_out_1bit (
            .clk   (CLK),
            .rst_n (RSTN),
            .d1    (tx_reg_q[i]),
            .d2    (tx_hi_q[i]),
            .q     (DDR_OUT[i])
        );
    end

    ddr_transmitter_24bit_ddr_out_1bit u_ddr_clk_out (
        .clk   (CLK),
        .rst_n (RSTN),
        .d1    (1'b1),
        .d2    (1'b0),
        .q     (DDR_CLK_OUT)
    );
endmodule

// File: tb/tb_ddr_transmitter_24bit.sv
// tb/tb_ddr_transmitter_24bit.sv - scoreboard bench for the 24-bit DDR transmitter
module tb_ddr_transmitter_24bit;
    import ddr_transmitter_24bit_pkg::*;

    localparam int          DEPTH  = 4;
    localparam int          TC     = 64;
    localparam logic [31:0] W_INIT = 32'hFFFF_FF00;
    localparam logic [15:0] U_INIT = 16'hFFF0;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        TRAIN_REQ = 1'b0;
    logic [23:0] din = '0;
    logic        dvalid = 1'b0;

    logic        training_a, training_b, ddrclk_a, ddrclk_b;
    logic [11:0] ddr_a, ddr_b;
    logic [31:0] words_a, words_b;
    logic [15:0] under_a, under_b;

    ddr_transmitter_24bit_if a_if ();
    ddr_transmitter_24bit_if b_if ();
    assign a_if.DATA_IN    = din;
    assign a_if.DATA_VALID = dvalid;
    assign b_if.DATA_IN    = din;
    assign b_if.DATA_VALID = dvalid;

    ddr_transmitter_24bit #(.FIFO_DEPTH(DEPTH), .TRAIN_CYCLES(TC)) dut_a (
        .CLK(CLK), .RSTN(RSTN), .in_if(a_if), .TRAIN_REQ(TRAIN_REQ), .TRAINING(training_a),
        .DDR_OUT(ddr_a), .DDR_CLK_OUT(ddrclk_a), .WORDS_SENT(words_a), .UNDERRUNS(under_a));

    // Preloaded counters reach the 2^32 wrap and 16'hFFFF saturation in a short run.
    ddr_transmitter_24bit #(.FIFO_DEPTH(DEPTH), .TRAIN_CYCLES(TC),
                            .WORDS_SENT_INIT(W_INIT), .UNDERRUNS_INIT(U_INIT)) dut_b (
        .CLK(CLK), .RSTN(RSTN), .in_if(b_if), .TRAIN_REQ(TRAIN_REQ), .TRAINING(training_b),
        .DDR_OUT(ddr_b), .DDR_CLK_OUT(ddrclk_b), .WORDS_SENT(words_b), .UNDERRUNS(under_b));

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: words leave the FIFO in order, one per cycle while any are queued.
    typedef struct packed { logic [23:0] w; logic tr; } ent_t;
    ent_t        txq[$];
    logic [23:0] mfifo[$];
    int          m_state;   // 0 training, 1 idle, 2 sending
    int          m_cnt;
    logic [31:0] m_words;
    int          m_under;
    bit          m_acc;

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            txq.delete();
            txq.push_back('{w: IDLE_WORD, tr: 1'b0});
            mfifo.delete();
            m_state = 0; m_cnt = 0; m_words = '0; m_under = 0; m_acc = 1'b0;
        end else begin
            ent_t e;
            bit   pop;
            m_acc = dvalid && (mfifo.size() < DEPTH) && (m_state != 0);
            e = '{w: IDLE_WORD, tr: 1'b0};
            pop = 1'b0;
            if (TRAIN_REQ) begin
                m_state = 0; m_cnt = 1; e = '{w: TRAIN_WORD, tr: 1'b1};
            end else if (m_state == 0) begin
                if (m_cnt == TC) begin
                    pop = (mfifo.size() > 0);
                    m_state = pop ? 2 : 1;
                end else begin
                    m_cnt++; e = '{w: TRAIN_WORD, tr: 1'b1};
                end
            end else if (mfifo.size() > 0) begin
                pop = 1'b1; m_state = 2;
            end else if (m_state == 2) begin
                m_state = 1; m_under++;
            end
            if (pop) begin
                e.w = mfifo.pop_front();
                m_words = m_words + 32'd1;
            end
            if (m_acc) mfifo.push_back(din);
            txq.push_back(e);
        end
    end

    ent_t cur;
    bit   cur_ok = 1'b0;

    always @(posedge CLK) begin
        #1;
        if (!RSTN) begin
            cur_ok = 1'b0;
            chk("rst_ddr_out", {20'd0, ddr_a}, 32'd0);
            chk("rst_ddr_clk", {31'd0, ddrclk_a}, 32'd0);
            chk("rst_training", {31'd0, training_a}, 32'd0);
            chk("rst_ready", {31'd0, a_if.DATA_READY}, 32'd0);
            chk("rst_words", words_a, 32'd0);
            chk("rst_under", {16'd0, under_a}, 32'd0);
            chk("rst_words_b", words_b, W_INIT);
            chk("rst_under_b", {16'd0, under_b}, {16'd0, U_INIT});
        end else begin
            int ua, ub;
            bit rdy;
            chk("clk_rise", {31'd0, ddrclk_a}, 32'd1);
            if (txq.size() >= 2) begin
                cur = txq.pop_front();
                cur_ok = 1'b1;
                chk("ddr_lo", {20'd0, ddr_a}, {20'd0, cur.w[11:0]});
                chk("ddr_lo_b", {20'd0, ddr_b}, {20'd0, cur.w[11:0]});
                chk("training", {31'd0, training_a}, {31'd0, cur.tr});
                chk("training_b", {31'd0, training_b}, {31'd0, cur.tr});
            end else begin
                cur_ok = 1'b0;
            end
            rdy = (mfifo.size() < DEPTH) && (m_state != 0);
            chk("ready", {31'd0, a_if.DATA_READY}, {31'd0, rdy});
            chk("ready_b", {31'd0, b_if.DATA_READY}, {31'd0, rdy});
            ua = (m_under > 65535) ? 65535 : m_under;
            ub = (int'(U_INIT) + m_under > 65535) ? 65535 : int'(U_INIT) + m_under;
            chk("words", words_a, m_words);
            chk("under", {16'd0, under_a}, ua);
            chk("words_b_wrap", words_b, W_INIT + m_words);
            chk("under_b_sat", {16'd0, under_b}, ub);
        end
    end

    always @(negedge CLK) begin
        #1;
        if (RSTN) begin
            chk("clk_fall", {31'd0, ddrclk_a}, 32'd0);
            if (cur_ok) begin
                chk("ddr_hi", {20'd0, ddr_a}, {20'd0, cur.w[23:12]});
                chk("ddr_hi_b", {20'd0, ddr_b}, {20'd0, cur.w[23:12]});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #2;
            TRAIN_REQ = 1'b0;
        end
    endtask

    // Holds the word until the model sees it accepted; a pending TRAIN_REQ lasts one edge.
    task automatic push_word(input logic [23:0] w);
        int n;
        n = 0;
        din = w;
        dvalid = 1'b1;
        forever begin
            @(posedge CLK); #1;
            TRAIN_REQ = 1'b0;
            if (m_acc) break;
            n++;
            if (n > 300) begin
                n_chk++;
                $display("FAIL push_timeout: word %h not accepted after %0d cycles", w, n);
                break;
            end
        end
        #1;
        dvalid = 1'b0;
    endtask

    initial begin
        idle(3);
        RSTN = 1'b1;
        idle(TC + 10);

        push_word(24'h123456);
        idle(10);

        for (int i = 1; i <= 16; i++) push_word(24'(i));
        idle(5);

        for (int i = 17; i <= 28; i++) begin
            if (i == 22) TRAIN_REQ = 1'b1;
            push_word(24'(i));
        end
        idle(TC + 10);

        push_word(24'hABCDEF);
        @(posedge CLK); #3;
        RSTN = 1'b0;
        #1;
        chk("async_ddr_out", {20'd0, ddr_a}, 32'd0);
        chk("async_ddr_clk", {31'd0, ddrclk_a}, 32'd0);
        chk("async_words", words_a, 32'd0);
        idle(2);
        RSTN = 1'b1;
        idle(TC + 5);

        for (int c = 0; c < 2000; c++) begin
            dvalid    = ($urandom_range(99) < 45);
            din       = 24'($urandom);
            TRAIN_REQ = ($urandom_range(999) < 4);
            @(posedge CLK); #2;
        end
        dvalid = 1'b0;
        TRAIN_REQ = 1'b0;
        idle(TC + 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
